// File: rtl/sbc_proto_pkg.sv
// Shared protocol definitions for the single-byte-command / two-byte-response
// exchange with the DHT11 controller: command and reply byte values, the
// result classes and the requester state encoding.
package sbc_proto_pkg;

    localparam logic [7:0] CMD_STATUS   = 8'd3;
    localparam logic [7:0] CMD_TEMP     = 8'd4;
    localparam logic [7:0] CMD_UMI      = 8'd5;

    localparam logic [7:0] RSP_OK       = 8'd102;
    localparam logic [7:0] RSP_SENS_ERR = 8'd31;
    localparam logic [7:0] RSP_INVALID  = 8'd126;

    typedef enum logic [2:0] {
        ST_DATA     = 3'd0,
        ST_SENS_OK  = 3'd1,
        ST_SENS_ERR = 3'd2,
        ST_INVALID  = 3'd3,
        ST_TIMEOUT  = 3'd4,
        ST_MISMATCH = 3'd5
    } sbc_status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND   = 3'd1,
        S_RX_B1  = 3'd2,
        S_RX_B2  = 3'd3,
        S_DECODE = 3'd4
    } sbc_state_e;

    // Classify a completed (non-timed-out) reply against the command sent.
    function automatic sbc_status_e sbc_classify(input logic [7:0] cmd,
                                                 input logic [7:0] hi,
                                                 input logic [7:0] lo);
        sbc_status_e res;
        res = ST_MISMATCH;
        if (cmd == CMD_TEMP || cmd == CMD_UMI) begin
            res = ST_DATA;
        end else if (cmd == CMD_STATUS) begin
            if (hi == RSP_OK && lo == RSP_OK)
                res = ST_SENS_OK;
            else if (hi == RSP_SENS_ERR && lo == RSP_SENS_ERR)
                res = ST_SENS_ERR;
        end else if (hi == RSP_INVALID && lo == RSP_INVALID) begin
            res = ST_INVALID;
        end
        return res;
    endfunction

endpackage

// File: rtl/sbc_requester_if.sv
// Handshake/bus bundle of the requester: host request side, UART TX/RX side
// and the result outputs. master = requester, slave = its environment.
interface sbc_requester_if;
    logic       Start;
    logic [7:0] Cmd;
    logic [7:0] TxData;
    logic       Enable_tx;
    logic       Tx_done;
    logic       Rx_done;
    logic [7:0] Rx_data;
    logic       Busy;
    logic       Done;
    logic [7:0] Byte_hi;
    logic [7:0] Byte_lo;
    logic [2:0] Status;

    modport master (
        input  Start, Cmd, Tx_done, Rx_done, Rx_data,
        output TxData, Enable_tx, Busy, Done, Byte_hi, Byte_lo, Status
    );

    modport slave (
        output Start, Cmd, Tx_done, Rx_done, Rx_data,
        input  TxData, Enable_tx, Busy, Done, Byte_hi, Byte_lo, Status
    );
endinterface

// File: rtl/sbc_requester_req_timer.sv
// Wait-state timeout counter: clear has priority over enable; the count stops
// at TIMEOUT_CYCLES-1 and raises expired while it sits there.
module req_timer #(
    parameter int TIMEOUT_CYCLES = 150000000,
    parameter int CNT_W          = 28
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LAST);

    // Next count: clear, else count up while enabled and not yet expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sbc_requester.sv
// Host-side initiator of the DHT11 controller UART exchange: sends one command
// byte, collects two reply bytes, classifies them and strobes Done.
// Optional build macro SBC_REQ_RETRY_EN: the first timeout of an exchange
// resends the latched command once instead of reporting TIMEOUT.
module sbc_requester
    import sbc_proto_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 150000000,
    parameter int CNT_W          = 28
) (
    input logic             Clk,
    input logic             Rst,
    sbc_requester_if.master bus
);
    sbc_state_e  state_q, state_d;
    sbc_status_e status_q, status_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  txdata_q, txdata_d;
    logic [7:0]  byte_hi_q, byte_hi_d;
    logic [7:0]  byte_lo_q, byte_lo_d;
    logic        en_tx_q, en_tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tmo_q, tmo_d;
    logic        rx_q;
`ifdef SBC_REQ_RETRY_EN
    logic        retry_q, retry_d;
`endif

    logic timer_clr, timer_en, expired, rx_edge, tmo_hit;

    // A held-high Rx_done counts once; stale levels from IDLE/SEND never edge.
    assign rx_edge = bus.Rx_done & ~rx_q;

    req_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_timer (
        .Clk     (Clk),
        .Rst     (Rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    // Next-state and output logic; events beat a simultaneous timeout.
    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        cmd_d     = cmd_q;
        txdata_d  = txdata_q;
        byte_hi_d = byte_hi_q;
        byte_lo_d = byte_lo_q;
        en_tx_d   = en_tx_q;
        tmo_d     = tmo_q;
        done_d    = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        tmo_hit   = 1'b0;
`ifdef SBC_REQ_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                timer_clr = 1'b1;
                if (bus.Start) begin
                    cmd_d     = bus.Cmd;
                    txdata_d  = bus.Cmd;
                    en_tx_d   = 1'b1;
                    byte_hi_d = '0;
                    byte_lo_d = '0;
                    tmo_d     = 1'b0;
`ifdef SBC_REQ_RETRY_EN
                    retry_d   = 1'b0;
`endif
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                timer_en = 1'b1;
                if (bus.Tx_done) begin
                    en_tx_d   = 1'b0;
                    timer_clr = 1'b1;
                    state_d   = S_RX_B1;
                end else if (expired) begin
                    tmo_hit = 1'b1;
                end
            end
            S_RX_B1: begin
                timer_en = 1'b1;
                if (rx_edge) begin
                    byte_hi_d = bus.Rx_data;
                    timer_clr = 1'b1;
                    state_d   = S_RX_B2;
                end else if (expired) begin
                    tmo_hit = 1'b1;
                end
            end
            S_RX_B2: begin
                timer_en = 1'b1;
                if (rx_edge) begin
                    byte_lo_d = bus.Rx_data;
                    state_d   = S_DECODE;
                end else if (expired) begin
                    tmo_hit = 1'b1;
                end
            end
            S_DECODE: begin
                done_d   = 1'b1;
                status_d = tmo_q ? ST_TIMEOUT : sbc_classify(cmd_q, byte_hi_q, byte_lo_q);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_hit) begin
`ifdef SBC_REQ_RETRY_EN
            if (!retry_q) begin
                retry_d   = 1'b1;
                en_tx_d   = 1'b1;
                timer_clr = 1'b1;
                state_d   = S_SEND;
            end else begin
                en_tx_d = 1'b0;
                tmo_d   = 1'b1;
                state_d = S_DECODE;
            end
`else
            en_tx_d = 1'b0;
            tmo_d   = 1'b1;
            state_d = S_DECODE;
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= S_IDLE;
            status_q  <= ST_DATA;
            cmd_q     <= '0;
            txdata_q  <= '0;
            byte_hi_q <= '0;
            byte_lo_q <= '0;
            en_tx_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            rx_q      <= 1'b0;
`ifdef SBC_REQ_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            cmd_q     <= cmd_d;
            txdata_q  <= txdata_d;
            byte_hi_q <= byte_hi_d;
            byte_lo_q <= byte_lo_d;
            en_tx_q   <= en_tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            rx_q      <= bus.Rx_done;
`ifdef SBC_REQ_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign bus.TxData    = txdata_q;
    assign bus.Enable_tx = en_tx_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Byte_hi   = byte_hi_q;
    assign bus.Byte_lo   = byte_lo_q;
    assign bus.Status    = status_q;
endmodule

// File: tb/tb_sbc_requester.sv
// Directed testbench for sbc_requester with TIMEOUT_CYCLES=1000.
module tb_sbc_requester;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    sbc_requester_if bus();

    sbc_requester #(.TIMEOUT_CYCLES(1000), .CNT_W(28)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int tx_rise  = 0;
    logic en_prev = 1'b0;
    logic [7:0] d_hi, d_lo;
    logic [2:0] d_st;

    always @(posedge Clk) cyc = cyc + 1;

    // Record every Done strobe and every rising edge of Enable_tx.
    always @(negedge Clk) begin
        if (bus.Done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            d_hi = bus.Byte_hi;
            d_lo = bus.Byte_lo;
            d_st = bus.Status;
        end
        if (bus.Enable_tx === 1'b1 && en_prev !== 1'b1) tx_rise = tx_rise + 1;
        en_prev = bus.Enable_tx;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic start_cmd(input logic [7:0] c);
        bus.Cmd   = c;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic tx_ack(input int delay);
        repeat (delay) tick();
        bus.Tx_done = 1'b1;
        tick();
        bus.Tx_done = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] v, input int hold);
        bus.Rx_data = v;
        bus.Rx_done = 1'b1;
        repeat (hold) tick();
        bus.Rx_done = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int base, input int lim, output bit ok);
        for (int i = 0; i < lim && done_cnt == base; i++) tick();
        ok = (done_cnt != base);
    endtask

    task automatic test_reset;
        bus.Start = 0; bus.Cmd = 0; bus.Tx_done = 0; bus.Rx_done = 0; bus.Rx_data = 0;
        Rst = 1'b0;
        tick(); tick();
        total++;
        if ({bus.TxData, bus.Enable_tx, bus.Busy, bus.Done, bus.Byte_hi, bus.Byte_lo, bus.Status} !== 30'd0) begin
            bad++;
            $display("FAIL reset_outputs got tx=%0d en=%0b busy=%0b done=%0b hi=%0d lo=%0d st=%0d want all 0",
                     bus.TxData, bus.Enable_tx, bus.Busy, bus.Done, bus.Byte_hi, bus.Byte_lo, bus.Status);
        end
        Rst = 1'b1;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_data_cmd;
        int base, hold_bad;
        bit ok;
        base = done_cnt;
        hold_bad = 0;
        start_cmd(8'd4);
        total++;
        if (bus.TxData !== 8'd4 || bus.Busy !== 1'b1) begin
            bad++;
            $display("FAIL launch got tx=%0d busy=%0b want tx=4 busy=1", bus.TxData, bus.Busy);
        end
        for (int i = 0; i < 10; i++) begin
            if (bus.Enable_tx !== 1'b1) hold_bad++;
            tick();
        end
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL en_tx_hold got %0d low cycles want 0", hold_bad);
        end
        bus.Tx_done = 1'b1;
        tick();
        bus.Tx_done = 1'b0;
        total++;
        if (bus.Enable_tx !== 1'b0) begin
            bad++;
            $display("FAIL en_tx_drop got %0b want 0", bus.Enable_tx);
        end
        rx_byte(8'd25, 1);
        rx_byte(8'd7, 1);
        wait_done(base, 10, ok);
        repeat (3) tick();
        total++;
        if (!ok || done_cnt != base + 1 || d_hi !== 8'd25 || d_lo !== 8'd7 || d_st !== 3'd0) begin
            bad++;
            $display("FAIL cmd4_result got dones=%0d hi=%0d lo=%0d st=%0d want dones=1 hi=25 lo=7 st=0",
                     done_cnt - base, d_hi, d_lo, d_st);
        end
        total++;
        if (bus.Busy !== 1'b0 || bus.Status !== 3'd0) begin
            bad++;
            $display("FAIL cmd4_idle got busy=%0b st=%0d want busy=0 st=0", bus.Busy, bus.Status);
        end
        $display("cmd4: hi=%0d lo=%0d st=%0d", d_hi, d_lo, d_st);
    endtask

    task automatic test_status_cmd;
        logic [7:0] hi_t [3] = '{8'd102, 8'd31, 8'd31};
        logic [7:0] lo_t [3] = '{8'd102, 8'd31, 8'd102};
        logic [2:0] st_t [3] = '{3'd1, 3'd2, 3'd5};
        int base;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            base = done_cnt;
            start_cmd(8'd3);
            tx_ack(2);
            rx_byte(hi_t[k], 1);
            rx_byte(lo_t[k], 1);
            wait_done(base, 10, ok);
            tick();
            total++;
            if (!ok || d_st !== st_t[k] || d_hi !== hi_t[k] || d_lo !== lo_t[k]) begin
                bad++;
                $display("FAIL cmd3_case%0d got st=%0d hi=%0d lo=%0d want st=%0d hi=%0d lo=%0d",
                         k, d_st, d_hi, d_lo, st_t[k], hi_t[k], lo_t[k]);
            end
            $display("cmd3 %0d/%0d: st=%0d", hi_t[k], lo_t[k], d_st);
        end
    endtask

    task automatic test_held_rx;
        int base;
        bit ok;
        base = done_cnt;
        start_cmd(8'd9);
        tx_ack(1);
        rx_byte(8'd126, 5);
        rx_byte(8'd126, 5);
        wait_done(base, 10, ok);
        repeat (5) tick();
        total++;
        if (!ok || done_cnt != base + 1 || d_st !== 3'd3 || d_hi !== 8'd126 || d_lo !== 8'd126) begin
            bad++;
            $display("FAIL cmd9_held got dones=%0d st=%0d hi=%0d lo=%0d want dones=1 st=3 hi=126 lo=126",
                     done_cnt - base, d_st, d_hi, d_lo);
        end
        total++;
        if (bus.Busy !== 1'b0) begin
            bad++;
            $display("FAIL cmd9_idle got busy=%0b want 0", bus.Busy);
        end
        $display("cmd9 held: st=%0d", d_st);
    endtask

    task automatic test_timeout;
        int base, c0, rise0;
        bit ok;
        base = done_cnt;
        rise0 = tx_rise;
        start_cmd(8'd5);
        tx_ack(0);
        bus.Rx_data = 8'd60;
        bus.Rx_done = 1'b1;
        c0 = cyc;
        tick();
        bus.Rx_done = 1'b0;
`ifdef SBC_REQ_RETRY_EN
        wait_done(base, 2600, ok);
        total++;
        if (!ok || tx_rise - rise0 != 2 || bus.TxData !== 8'd5) begin
            bad++;
            $display("FAIL retry_resend got done=%0b tx_starts=%0d tx=%0d want done=1 tx_starts=2 tx=5",
                     ok, tx_rise - rise0, bus.TxData);
        end
`else
        wait_done(base, 1100, ok);
        // Byte captured at edge c0+1 clears the counter; it reaches 999 after
        // c0+1000, DECODE is entered at c0+1001 and Done registers at c0+1002.
        total++;
        if (!ok || done_cyc - c0 != 1002 || tx_rise - rise0 != 1) begin
            bad++;
            $display("FAIL timeout_latency got done=%0b lat=%0d tx_starts=%0d want done=1 lat=1002 tx_starts=1",
                     ok, done_cyc - c0, tx_rise - rise0);
        end
`endif
        tick();
        total++;
        if (d_st !== 3'd4 || d_hi !== 8'd60 || d_lo !== 8'd0 || bus.Enable_tx !== 1'b0) begin
            bad++;
            $display("FAIL timeout_result got st=%0d hi=%0d lo=%0d en=%0b want st=4 hi=60 lo=0 en=0",
                     d_st, d_hi, d_lo, bus.Enable_tx);
        end
        $display("timeout: st=%0d hi=%0d lo=%0d", d_st, d_hi, d_lo);
    endtask

    task automatic test_reset_mid;
        int base;
        base = done_cnt;
        start_cmd(8'd4);
        tx_ack(1);
        rx_byte(8'd11, 1);
        start_cmd(8'd9);
        total++;
        if (bus.TxData !== 8'd4 || bus.Enable_tx !== 1'b0 || bus.Busy !== 1'b1 || bus.Byte_hi !== 8'd11) begin
            bad++;
            $display("FAIL busy_start got tx=%0d en=%0b busy=%0b hi=%0d want tx=4 en=0 busy=1 hi=11",
                     bus.TxData, bus.Enable_tx, bus.Busy, bus.Byte_hi);
        end
        #2;
        Rst = 1'b0;
        #1;
        total++;
        if ({bus.TxData, bus.Enable_tx, bus.Busy, bus.Done, bus.Byte_hi, bus.Byte_lo, bus.Status} !== 30'd0) begin
            bad++;
            $display("FAIL async_reset got tx=%0d en=%0b busy=%0b done=%0b hi=%0d lo=%0d st=%0d want all 0",
                     bus.TxData, bus.Enable_tx, bus.Busy, bus.Done, bus.Byte_hi, bus.Byte_lo, bus.Status);
        end
        tick(); tick();
        Rst = 1'b1;
        repeat (20) tick();
        total++;
        if (done_cnt != base || bus.Busy !== 1'b0 || bus.Enable_tx !== 1'b0) begin
            bad++;
            $display("FAIL reset_abandon got dones=%0d busy=%0b en=%0b want dones=0 busy=0 en=0",
                     done_cnt - base, bus.Busy, bus.Enable_tx);
        end
        $display("reset mid-exchange: dones=%0d", done_cnt - base);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_data_cmd();
        test_status_cmd();
        test_held_rx();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
